store_buffer: RTL and testbench
===============================

# store_buffer

Posted-write buffer between the store data aligner and the data memory write port. It accepts word-aligned store data with byte enables from the memory stage and queues them in a small FIFO. It drains entries to data memory over a req/ack handshake, so the pipeline does not stall on memory write latency. It also flags read-after-write hazards for loads that hit a pending store.

## Interface
- DEPTH, 4: number of buffer entries; a power of two, at least 2.
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- wr_valid  in  1  a store is offered this cycle.
- wr_ready  out  1  the buffer accepts the offered store.
- wr_addr  in  32  store byte address; only bits [31:2] are used.
- wr_data  in  32  store data, already lane-aligned.
- wr_be  in  4  byte enables, one bit per byte lane; bit 0 is bits [7:0].
- mem_req  out  1  the head entry is presented to memory.
- mem_addr  out  32  head word address; bits [1:0] are always 0.
- mem_wdata  out  32  head data.
- mem_be  out  4  head byte enables.
- mem_ack  in  1  memory accepts the head this cycle.
- ld_addr  in  32  address of the load in the memory stage.
- ld_hazard  out  1  at least one valid entry has the same word address as ld_addr[31:2].
- empty  out  1  no valid entries.
- count  out  $clog2(DEPTH+1)  number of valid entries.

## Operation
- Circular FIFO with head and tail pointers and an occupancy counter; pointers wrap modulo DEPTH.
- Push: on a cycle with wr_valid && wr_ready, write {wr_addr[31:2], wr_data, wr_be} at tail, advance tail, and increment count.
- wr_ready = (count != DEPTH).
  - wr_ready does not depend on mem_ack, so there is no combinational path from the memory side to the pipeline.
  - A push is refused when the buffer is full, even if an ack arrives in the same cycle.
- A push with wr_be == 4'b0000 is accepted (wr_ready applies) but allocates nothing.
- Drain:
  - mem_req = !empty.
  - mem_addr = {head_addr, 2'b00}; mem_wdata and mem_be come from the head entry.
  - On mem_req && mem_ack: retire the head, advance head, decrement count.
  - mem_ack while mem_req is low is ignored.
- Simultaneous push and retire: count is unchanged and both pointers advance.
- Memory ordering: entries drain strictly in push order.
- The mem_* outputs hold stable from the rising edge of mem_req until the acking cycle.
- ld_hazard:
  - Combinational OR over all valid entries of (entry_addr == ld_addr[31:2]).
  - Based on registered state only; a store pushed in the same cycle is not included.
  - The pipeline stalls the load while ld_hazard is high.
- empty = (count == 0).

## Timing
- Reset values: count = 0, empty = 1, mem_req = 0, wr_ready = 1, ld_hazard = 0, head = tail = 0.
- mem_addr, mem_wdata and mem_be are 0 after reset; they are don't-care while mem_req = 0.
- Latency: a push into an empty buffer asserts mem_req on the next cycle.
- Throughput: one push per cycle and one retire per cycle.
- Reset mid-operation: all entries are discarded immediately and asynchronously. An in-flight request is dropped, and memory must tolerate mem_req falling without an ack.
- Boundaries:
  - Full with wr_valid: wr_ready = 0 and the state holds.
  - Empty with mem_ack: no effect.
  - Pointer wrap from DEPTH-1 to 0 is seamless.

## Configuration
- STORE_MERGE_EN defined:
  - A push is merged into the tail-most valid entry when that entry's word address equals wr_addr[31:2] and it is not the head (count >= 2).
  - Merge: each byte lane with wr_be set overwrites that lane's data; be becomes old_be | wr_be; no allocation, count unchanged.
  - A merge is allowed when the buffer is full, so wr_ready = (count != DEPTH) || merge_hit.
  - The head is never merged into, because it may be under an outstanding request.
- STORE_MERGE_EN undefined: every push allocates a new entry. No comparator exists on the write path.

## Test plan
- Single store:
  - Stimulus: push addr 0x100, data 0x000000AB, be 0001, with mem_ack tied high.
  - Response: next cycle mem_req = 1, mem_addr = 0x100, mem_wdata = 0x000000AB, mem_be = 0001; the following cycle empty = 1.
- Fill and backpressure:
  - Stimulus: DEPTH = 4, mem_ack low, push 5 stores to distinct addresses.
  - Response: count = 4, wr_ready = 0 on the 5th. Then assert mem_ack for 4 cycles: stores drain in push order, count reaches 0.
- Simultaneous push and retire with 2 entries:
  - Response: count stays 2, order is preserved, and head/tail wrap correctly over 8 such cycles.
- Hazard:
  - Stimulus: entries at 0x200 and 0x304; ld_addr = 0x206.
  - Response: ld_hazard = 0. With ld_addr = 0x307, ld_hazard = 1; it drops in the cycle after the 0x304 entry is acked.
- Merge (STORE_MERGE_EN):
  - Stimulus: mem_ack low; push 0x400/be 0011/data 0x00001234, then 0x500/be 0011/0x00005678, then 0x500/be 1100/0xBEEF0000.
  - Response: count = 2. Second entry drains as data 0xBEEF5678, be 1111.
  - Without the macro, the same stimulus gives count = 3.
- Reset mid-operation:
  - Stimulus: 3 entries pending with mem_req high; pulse reset_n low.
  - Response: count = 0, mem_req = 0 immediately. Afterwards a new push behaves as in the single-store scenario.

Source files
------------

// File: rtl/store_buffer_if.sv
// Store buffer bus bundle: pipeline write port, memory drain port, load hazard probe and status.
// master = environment (pipeline + memory), slave = the store buffer itself.
interface store_buffer_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic            wr_valid;
  logic            wr_ready;
  logic [31:0]     wr_addr;
  logic [31:0]     wr_data;
  logic [3:0]      wr_be;
  logic            mem_req;
  logic [31:0]     mem_addr;
  logic [31:0]     mem_wdata;
  logic [3:0]      mem_be;
  logic            mem_ack;
  logic [31:0]     ld_addr;
  logic            ld_hazard;
  logic            empty;
  logic [CntW-1:0] count;

  modport master (
    output wr_valid, wr_addr, wr_data, wr_be, mem_ack, ld_addr,
    input  wr_ready, mem_req, mem_addr, mem_wdata, mem_be, ld_hazard, empty, count
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_be, mem_ack, ld_addr,
    output wr_ready, mem_req, mem_addr, mem_wdata, mem_be, ld_hazard, empty, count
  );
endinterface

// File: rtl/store_buffer.sv
// Posted-write store buffer: circular FIFO draining to data memory over req/ack, with load hazard.
// Optional STORE_MERGE_EN merges a push into the tail-most non-head entry with the same word.
module store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input logic          clk,
  input logic          reset_n,
  store_buffer_if.slave sb
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [29:0]     addr_q [DEPTH];
  logic [31:0]     data_q [DEPTH];
  logic [3:0]      be_q   [DEPTH];
  logic [PtrW-1:0] head_q, tail_q;
  logic [CntW-1:0] count_q;

  logic            merge_hit;
  logic            wr_ready;
  logic            push, alloc, retire;
  logic            hazard;
  logic [PtrW-1:0] off;
`ifdef STORE_MERGE_EN
  logic [PtrW-1:0] last_idx;
`endif

  always_comb begin
`ifdef STORE_MERGE_EN
    last_idx  = tail_q - PtrW'(1);
    // The head may be under request, so it is never a merge target.
    merge_hit = (count_q >= CntW'(2)) && (addr_q[last_idx] == sb.wr_addr[31:2]);
`else
    merge_hit = 1'b0;
`endif
    wr_ready = (count_q != CntW'(DEPTH)) || merge_hit;
    push     = sb.wr_valid && wr_ready;
    alloc    = push && (sb.wr_be != 4'b0000) && !merge_hit;
    retire   = (count_q != '0) && sb.mem_ack;
  end

  // Hazard looks at registered entries only; an entry is valid if its distance from head < count.
  always_comb begin
    hazard = 1'b0;
    off    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off = PtrW'(i) - head_q;
      if ((CntW'(off) < count_q) && (addr_q[i] == sb.ld_addr[31:2])) begin
        hazard = 1'b1;
      end
    end
  end

  always_comb begin
    sb.wr_ready  = wr_ready;
    sb.mem_req   = (count_q != '0);
    sb.mem_addr  = {addr_q[head_q], 2'b00};
    sb.mem_wdata = data_q[head_q];
    sb.mem_be    = be_q[head_q];
    sb.ld_hazard = hazard;
    sb.empty     = (count_q == '0);
    sb.count     = count_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        be_q[i]   <= '0;
      end
    end else begin
      if (alloc) begin
        addr_q[tail_q] <= sb.wr_addr[31:2];
        data_q[tail_q] <= sb.wr_data;
        be_q[tail_q]   <= sb.wr_be;
        tail_q         <= tail_q + PtrW'(1);
      end
`ifdef STORE_MERGE_EN
      if (push && merge_hit) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (sb.wr_be[b]) begin
            data_q[last_idx][8*b +: 8] <= sb.wr_data[8*b +: 8];
          end
        end
        be_q[last_idx] <= be_q[last_idx] | sb.wr_be;
      end
`endif
      if (retire) begin
        head_q <= head_q + PtrW'(1);
      end
      if (alloc && !retire) begin
        count_q <= count_q + CntW'(1);
      end else if (!alloc && retire) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: driver updates a queue model, monitor checks every cycle.
module tb_store_buffer;
  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [29:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } entry_t;

  logic clk;
  logic reset_n;
  store_buffer_if #(.DEPTH(DEPTH)) sb ();

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sb      (sb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  entry_t exp_q[$];
  int     checks   = 0;
  int     failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic bit m_merge(input logic [31:0] addr);
`ifdef STORE_MERGE_EN
    return (exp_q.size() >= 2) && (exp_q[exp_q.size()-1].a == addr[31:2]);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_ready(input logic [31:0] addr);
    return (exp_q.size() != DEPTH) || m_merge(addr);
  endfunction

  function automatic bit m_hazard(input logic [31:0] addr);
    foreach (exp_q[i]) if (exp_q[i].a == addr[31:2]) return 1'b1;
    return 1'b0;
  endfunction

  // Monitor: compares DUT outputs against the model mid-cycle, retires the model head on ack.
  initial begin
    bit hs;
    forever begin
      @(negedge clk);
      hs = 1'b0;
      if (reset_n) begin
        chk("count", 32'(sb.count), 32'(exp_q.size()));
        chk("empty", 32'(sb.empty), 32'(exp_q.size() == 0));
        chk("mem_req", 32'(sb.mem_req), 32'(exp_q.size() != 0));
        chk("wr_ready", 32'(sb.wr_ready), 32'(m_ready(sb.wr_addr)));
        chk("ld_hazard", 32'(sb.ld_hazard), 32'(m_hazard(sb.ld_addr)));
        if (exp_q.size() != 0) begin
          chk("mem_addr", sb.mem_addr, {exp_q[0].a, 2'b00});
          chk("mem_wdata", sb.mem_wdata, exp_q[0].d);
          chk("mem_be", 32'(sb.mem_be), 32'(exp_q[0].be));
          hs = sb.mem_ack;
        end
      end
      @(posedge clk);
      #1;
      if (hs && reset_n) void'(exp_q.pop_front());
    end
  end

  // Drive one cycle of inputs, then apply the accepted push to the model after the edge.
  task automatic step(input bit v, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, input bit ack, input logic [31:0] ld);
    bit     acc, mrg;
    entry_t t;
    sb.wr_valid = v;
    sb.wr_addr  = a;
    sb.wr_data  = d;
    sb.wr_be    = be;
    sb.mem_ack  = ack;
    sb.ld_addr  = ld;
    acc = v && m_ready(a);
    mrg = m_merge(a);
    @(posedge clk);
    #1;
    if (acc) begin
      if (mrg) begin
        t = exp_q[exp_q.size()-1];
        for (int b = 0; b < 4; b++) if (be[b]) t.d[8*b +: 8] = d[8*b +: 8];
        t.be = t.be | be;
        exp_q[exp_q.size()-1] = t;
      end else if (be != 4'b0000) begin
        t.a  = a[31:2];
        t.d  = d;
        t.be = be;
        exp_q.push_back(t);
      end
    end
    #1;
  endtask

  task automatic idle(input bit ack);
    step(1'b0, 32'h0, 32'h0, 4'h0, ack, 32'hFFFF_FFF0);
  endtask

  task automatic do_reset();
    sb.wr_valid = 1'b0;
    sb.mem_ack  = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_count", 32'(sb.count), 32'd0);
    chk("rst_mem_req", 32'(sb.mem_req), 32'd0);
    chk("rst_empty", 32'(sb.empty), 32'd1);
    chk("rst_wr_ready", 32'(sb.wr_ready), 32'd1);
    exp_q.delete();
    @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic single_store();
    step(1'b1, 32'h100, 32'h0000_00AB, 4'b0001, 1'b1, 32'hFFFF_FFF0);
    #1;
    chk("ss_mem_req", 32'(sb.mem_req), 32'd1);
    chk("ss_mem_addr", sb.mem_addr, 32'h100);
    chk("ss_mem_wdata", sb.mem_wdata, 32'h0000_00AB);
    chk("ss_mem_be", 32'(sb.mem_be), 32'h1);
    idle(1'b1);
    #1;
    chk("ss_empty", 32'(sb.empty), 32'd1);
  endtask

  initial begin
    logic [31:0] a;
    reset_n     = 1'b0;
    sb.wr_valid = 1'b0;
    sb.wr_addr  = '0;
    sb.wr_data  = '0;
    sb.wr_be    = '0;
    sb.mem_ack  = 1'b0;
    sb.ld_addr  = 32'hFFFF_FFF0;
    #2;
    chk("init_count", 32'(sb.count), 32'd0);
    chk("init_empty", 32'(sb.empty), 32'd1);
    chk("init_mem_req", 32'(sb.mem_req), 32'd0);
    chk("init_wr_ready", 32'(sb.wr_ready), 32'd1);
    chk("init_ld_hazard", 32'(sb.ld_hazard), 32'd0);
    chk("init_mem_addr", sb.mem_addr, 32'd0);
    chk("init_mem_wdata", sb.mem_wdata, 32'd0);
    chk("init_mem_be", 32'(sb.mem_be), 32'd0);
    @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #2;

    single_store();

    // Fill to full with memory stalled, then try a fifth store.
    for (int i = 0; i < 5; i++) step(1'b1, 32'h1000 + 32'(i) * 16, 32'hA000_0000 + 32'(i),
                                     4'hF, 1'b0, 32'hFFFF_FFF0);
    #1;
    chk("fill_count", 32'(sb.count), 32'd4);
    for (int i = 0; i < 4; i++) idle(1'b1);
    #1;
    chk("drain_count", 32'(sb.count), 32'd0);

    // Two entries, then eight cycles of simultaneous push and retire across the wrap.
    step(1'b1, 32'h2000, 32'h1, 4'hF, 1'b0, 32'hFFFF_FFF0);
    step(1'b1, 32'h2010, 32'h2, 4'hF, 1'b0, 32'hFFFF_FFF0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 32'h2020 + 32'(i) * 16, 32'h10 + 32'(i), 4'hF, 1'b1, 32'hFFFF_FFF0);
      #1;
      chk("pr_count", 32'(sb.count), 32'd2);
    end
    idle(1'b1);
    idle(1'b1);

    // Load hazard against pending stores.
    step(1'b1, 32'h200, 32'h5, 4'hF, 1'b0, 32'h206);
    step(1'b1, 32'h304, 32'h6, 4'hF, 1'b0, 32'h206);
    #1;
    chk("hz_miss", 32'(sb.ld_hazard), 32'd0);
    step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h307);
    #1;
    chk("hz_hit", 32'(sb.ld_hazard), 32'd1);
    step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h307);
    #1;
    chk("hz_hit_after_first", 32'(sb.ld_hazard), 32'd1);
    step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h307);
    #1;
    chk("hz_drop", 32'(sb.ld_hazard), 32'd0);

    // Merge scenario.
    step(1'b1, 32'h400, 32'h0000_1234, 4'b0011, 1'b0, 32'hFFFF_FFF0);
    step(1'b1, 32'h500, 32'h0000_5678, 4'b0011, 1'b0, 32'hFFFF_FFF0);
    step(1'b1, 32'h500, 32'hBEEF_0000, 4'b1100, 1'b0, 32'hFFFF_FFF0);
    #1;
`ifdef STORE_MERGE_EN
    chk("mg_count", 32'(sb.count), 32'd2);
`else
    chk("mg_count", 32'(sb.count), 32'd3);
`endif
    idle(1'b1);
    #1;
`ifdef STORE_MERGE_EN
    chk("mg_wdata", sb.mem_wdata, 32'hBEEF_5678);
    chk("mg_be", 32'(sb.mem_be), 32'hF);
`else
    chk("mg_wdata", sb.mem_wdata, 32'h0000_5678);
    chk("mg_be", 32'(sb.mem_be), 32'h3);
`endif
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Reset with requests outstanding.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h600 + 32'(i) * 4, 32'(i), 4'hF, 1'b0,
                                     32'hFFFF_FFF0);
    #1;
    chk("pre_rst_req", 32'(sb.mem_req), 32'd1);
    do_reset();
    single_store();

    // Random traffic over a small address pool so merges and hazards occur.
    for (int i = 0; i < 600; i++) begin
      a = 32'h800 + 32'($urandom_range(0, 5)) * 4 + 32'($urandom_range(0, 3));
      step(($urandom_range(0, 3) != 0), a, $urandom(), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 2) == 0), 32'h800 + 32'($urandom_range(0, 7)) * 4);
    end
    for (int i = 0; i < 2 * DEPTH; i++) idle(1'b1);
    #1;
    chk("final_empty", 32'(sb.empty), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
